// File: rtl/cla_pkg.sv
// Shared constants and types for the carry-lookahead adder.
// gp_t carries one generate/propagate pair at either bit or group level.
package cla_pkg;
  localparam int CLA_WIDTH = 32;
  localparam int CLA_GROUP = 4;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;
endpackage

// File: rtl/cla_gp4.sv
// 4-wide lookahead cell: carries into positions 1..3 plus group G/P.
// Used on bit pairs (level 1) and on group pairs (level 2) alike.
module cla_gp4
  import cla_pkg::*;
(
  input  gp_t  [CLA_GROUP-1:0] gp,
  input  logic                 ci,
  output logic [CLA_GROUP-1:1] c,
  output gp_t                  grp
);

  logic [CLA_GROUP-1:0] g;
  logic [CLA_GROUP-1:0] p;

  always_comb begin
    for (int i = 0; i < CLA_GROUP; i++) begin
      g[i] = gp[i].g;
      p[i] = gp[i].p;
    end
  end

  // Every carry is a flat sum of products; nothing ripples inside the cell.
  always_comb begin
    c[1]  = g[0] | (p[0] & ci);
    c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    grp.g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    grp.p = &p;
  end

endmodule

// File: rtl/cla_32.sv
// Registered 32-bit carry-lookahead adder: {c0, s} <= a + b + ci.
// Free-running, no enable or handshake: inputs captured every rising edge.
module cla_32
  import cla_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CLA_WIDTH-1:0] a,
  input  logic [CLA_WIDTH-1:0] b,
  input  logic                 ci,
  output logic [CLA_WIDTH-1:0] s,
  output logic                 c0
);

  localparam int NGRP = CLA_WIDTH / CLA_GROUP;

  gp_t  [CLA_WIDTH-1:0] bit_gp;
  gp_t  [NGRP-1:0]      grp_gp;
  gp_t  [1:0]           sup_gp;
  logic [NGRP-1:0]      grp_ci;   // carry into each 4-bit group
  logic [CLA_WIDTH-1:0] bit_c;    // carry into each bit
  logic                 c16;
  logic                 c32;
  logic [CLA_WIDTH-1:0] sum;

  always_comb begin
    for (int i = 0; i < CLA_WIDTH; i++) begin
      bit_gp[i].g = a[i] & b[i];
      bit_gp[i].p = a[i] ^ b[i];
    end
  end

  for (genvar j = 0; j < NGRP; j++) begin : g_l1
    cla_gp4 u_l1 (
      .gp  (bit_gp[4*j+3 -: 4]),
      .ci  (grp_ci[j]),
      .c   (bit_c[4*j+3 -: 3]),
      .grp (grp_gp[j])
    );
    assign bit_c[4*j] = grp_ci[j];
  end

  cla_gp4 u_l2_lo (
    .gp  (grp_gp[3:0]),
    .ci  (ci),
    .c   (grp_ci[3:1]),
    .grp (sup_gp[0])
  );

  cla_gp4 u_l2_hi (
    .gp  (grp_gp[7:4]),
    .ci  (c16),
    .c   (grp_ci[7:5]),
    .grp (sup_gp[1])
  );

  // Level 3: carries across the two 16-bit super-blocks.
  assign c16       = sup_gp[0].g | (sup_gp[0].p & ci);
  assign c32       = sup_gp[1].g | (sup_gp[1].p & c16);
  assign grp_ci[0] = ci;
  assign grp_ci[4] = c16;

  always_comb begin
    for (int i = 0; i < CLA_WIDTH; i++) begin
      sum[i] = bit_gp[i].p ^ bit_c[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s  <= '0;
      c0 <= 1'b0;
    end else begin
      s  <= sum;
      c0 <= c32;
    end
  end

endmodule

// File: tb/tb_cla_32.sv
// Bench for cla_32: driver pushes expected {c0,s} into a queue, a monitor
// pops one entry per clock after each capturing edge and compares.
module tb_cla_32;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic [32:0] exp;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic        ci;
  logic [31:0] s;
  logic        c0;

  logic [32:0] exp_q[$];
  int          vec_cnt;
  int          miscmp;
  vec_t        dir_v[12];

  cla_32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .ci    (ci),
    .s     (s),
    .c0    (c0)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver tasks
  task automatic drive(input logic [31:0] va, input logic [31:0] vb,
                       input logic vci, input logic [32:0] vexp);
    @(negedge clk);
    a  = va;
    b  = vb;
    ci = vci;
    exp_q.push_back(vexp);
  endtask

  task automatic check_now(input string name, input logic [32:0] req);
    vec_cnt++;
    if ({c0, s} !== req) begin
      miscmp++;
      $display("FAIL %s: got c0=%b s=%h, want c0=%b s=%h",
               name, c0, s, req[32], req[31:0]);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      vec_cnt++;
      miscmp++;
      $display("FAIL %s: timeout, %0d expected results still queued, want 0",
               name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // scoreboard monitor: one result per edge while out of reset
  initial begin
    logic [32:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vec_cnt++;
        if ({c0, s} !== e) begin
          miscmp++;
          $display("FAIL sum: got c0=%b s=%h, want c0=%b s=%h",
                   c0, s, e[32], e[31:0]);
        end
      end
    end
  end

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rci;

    vec_cnt = 0;
    miscmp  = 0;

    dir_v[0]  = '{32'h77777777, 32'hFFFFFFFF, 1'b0, 33'h1_77777776};
    dir_v[1]  = '{32'hAAAAAAAA, 32'h55555555, 1'b0, 33'h0_FFFFFFFF};
    dir_v[2]  = '{32'hAAAAAAAA, 32'h55555555, 1'b1, 33'h1_00000000};
    dir_v[3]  = '{32'h00000000, 32'h00000000, 1'b0, 33'h0_00000000};
    dir_v[4]  = '{32'h00000000, 32'h00000000, 1'b1, 33'h0_00000001};
    dir_v[5]  = '{32'hCCCCCCCC, 32'hCCCCCCCC, 1'b0, 33'h1_99999998};
    dir_v[6]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 33'h1_FFFFFFFF};
    dir_v[7]  = '{32'h0000FFFF, 32'h00000001, 1'b0, 33'h0_00010000};
    dir_v[8]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 33'h0_80000000};
    dir_v[9]  = '{32'h0000FFFF, 32'hFFFF0000, 1'b1, 33'h1_00000000};
    dir_v[10] = '{32'h12345678, 32'h87654321, 1'b0, 33'h0_99999999};
    dir_v[11] = '{32'h0000000F, 32'h00000000, 1'b1, 33'h0_00000010};

    // reset clears asynchronously, before any clock edge
    rst_n = 1'b1;
    a     = 32'hFFFFFFFF;
    b     = 32'h00000001;
    ci    = 1'b0;
    #1 rst_n = 1'b0;
    #2 check_now("reset_async", 33'h0);
    repeat (3) @(posedge clk);
    #1 check_now("reset_hold", 33'h0);

    // release: first edge captures FFFFFFFF + 1
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(33'h1_00000000);

    for (int i = 0; i < 12; i++)
      drive(dir_v[i].a, dir_v[i].b, dir_v[i].ci, dir_v[i].exp);
    drain("directed");

    // mid-stream reset discards the in-flight sum
    @(negedge clk);
    a  = 32'h12345678;
    b  = 32'h11111111;
    ci = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_now("reset_mid", 33'h0);
    @(posedge clk);
    #1 check_now("reset_mid_edge", 33'h0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(33'h0_23456789 + 33'h1);
    drive(32'hFFFFFFFF, 32'h00000000, 1'b1, 33'h1_00000000);
    drain("after_reset");

    // back-to-back random vectors against the arithmetic reference
    for (int i = 0; i < 10000; i++) begin
      ra  = $urandom;
      rb  = $urandom;
      rci = 1'($urandom_range(0, 1));
      if (i % 16 == 0) rb = ~ra;
      drive(ra, rb, rci, {1'b0, ra} + {1'b0, rb} + {32'b0, rci});
    end
    drain("random");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end

endmodule

// File: doc/cla_32.md
# cla_32

Registered 32-bit carry-lookahead adder with carry-in and carry-out. It computes `a + b + ci` through a hierarchical generate/propagate lookahead tree rather than a ripple chain, and registers the 33-bit result. It serves as the adder primitive for the datapath/ALU, where it sits directly on a pipeline boundary.

## Interface
- Parameters: none. Width is fixed at 32 bits via the shared package constant.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `a` input 32: addend A, unsigned/two's-complement agnostic.
- `b` input 32: addend B.
- `ci` input 1: carry into bit 0.
- `s` output 32: registered sum bits [31:0].
- `c0` output 1: registered carry out of bit 31. The name `c0` means carry-out, not carry of bit 0.

## Operation
- Each rising `clk` with `rst_n` high: `{c0, s} <= a + b + ci`, computed modulo 2^33.
- Bit level: `g[i] = a[i] & b[i]`, `p[i] = a[i] ^ b[i]`, `s[i] = p[i] ^ c[i]`, with `c[0] = ci`.
- Level 1: eight 4-bit groups. Each group produces group generate `G` and group propagate `P`, and its internal carries come from lookahead equations, not a ripple.
  - `G = g3 | p3g2 | p3p2g1 | p3p2p1g0`
  - `P = p3p2p1p0`
- Level 2: two 4-group super-blocks, bits [15:0] and [31:16]. Each super-block produces carries into its groups and its own super G/P.
- Level 3: `c[16] = G_lo | P_lo & ci`; `c[32] = G_hi | P_hi & c[16]`.
- `c0 = c[32]`.
- No overflow flag. Signed overflow is the caller's responsibility (`c[31] ^ c[32]`, not exported).
- No ripple path longer than 4 bits anywhere. Logic depth scales with log4 of the width.
- Inputs are sampled every cycle. There is no enable and no handshake.

## Timing
- Latency: 1 cycle. Inputs presented before edge N appear on `s`/`c0` after edge N.
- Throughput: one addition per cycle.
- Reset: `rst_n` low immediately and asynchronously forces `s = 32'h0` and `c0 = 0`, and holds them while low.
- Reset release: the first rising edge with `rst_n` high captures the current inputs.
- Reset asserted mid-stream discards the in-flight result. No partial state survives.
- Combinational core is purely combinational. No latches, no combinational loops.
- Critical path: `a`/`b` → g/p → level-1 G/P → level-2 → level-3 carry → group carry → sum XOR → `s` flop D. Budget it against a single cycle.

## Structure
- Shared package `cla_pkg`:
  - `CLA_WIDTH = 32`
  - `CLA_GROUP = 4`
  - typedef `gp_t`, a packed struct of `{g, p}`
- One natural sub-module, `cla_gp4`: a 4-bit lookahead cell.
  - Inputs: four g/p pairs plus carry-in.
  - Outputs: three internal carries plus group G/P.
  - The same cell is reused at level 1 (bits) and at level 2 (groups).
- Top level `cla_32` contains:
  - bit g/p generation
  - 8 + 2 `cla_gp4` instances
  - final carry logic
  - sum XOR
  - the 33-bit output register with asynchronous clear

## Test plan
- Reset: assert `rst_n = 0` with `a = 32'hFFFFFFFF`, `b = 1` → `s = 0`, `c0 = 0` immediately, independent of `clk`. Release, then one edge → `s = 0`, `c0 = 1`.
- Borrow-style wrap: `a = 32'h77777777`, `b = 32'hFFFFFFFF`, `ci = 0` → next cycle `s = 32'h77777776`, `c0 = 1`.
- Full propagate chain: `a = 32'hAAAAAAAA`, `b = 32'h55555555`.
  - `ci = 0` → `s = 32'hFFFFFFFF`, `c0 = 0`.
  - `ci = 1` → `s = 32'h00000000`, `c0 = 1` (carry crosses all groups).
- Zero: `a = 0`, `b = 0`, `ci = 0` → `s = 0`, `c0 = 0`. With `ci = 1` → `s = 1`, `c0 = 0`.
- Generate-heavy: `a = b = 32'hCCCCCCCC`, `ci = 0` → `s = 32'h99999998`, `c0 = 1`.
- Back-to-back and random: change inputs every cycle for ≥10,000 random vectors. Each output must equal the 33-bit reference sum of the previous cycle's inputs, including all `ci` values.
